rah_hash_readback: RTL
======================

// Module: rah_hash_readback
// PURPOSE
//  Downstream of the SHA bridge on the RAH read path. Captures each 256-bit hash1 result
//  pulsed out by the SHA core, buffers up to two results, and serialises each into 48-bit
//  words written to the host read FIFO. The SHA core cannot be stalled, so overflow is
//  counted, never back-pressured.
// PARAMETERS
//  HASH_WIDTH   256  width of captured hash
//  CHUNK_WIDTH  48   read-FIFO word width
//  NUM_CHUNKS   6    ceil(HASH_WIDTH/CHUNK_WIDTH); words emitted per hash (excl. header)
//  DROP_WIDTH   16   width of saturating drop counter
// PORTS
//  clk              in   1     single clock; all logic rising-edge
//  rst_n            in   1     asynchronous, active-low reset
//  hash_valid       in   1     one-cycle pulse; hash_data valid this cycle
//  hash_data        in   256   hash1 result from SHA core
//  rd_fifo_full     in   1     host read FIFO full (registered flag from FIFO)
//  rd_fifo_wr_en    out  1     write strobe to read FIFO
//  rd_fifo_wr_data  out  48    word written when rd_fifo_wr_en=1
//  busy             out  1     1 while any result is buffered or being emitted
//  drop_count       out  16    saturating count of hashes dropped on overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): buffer empty, FSM=IDLE, chunk_idx=0, wr_en=0, wr_data=0,
//    busy=0, drop_count=0. Reset mid-emit discards all buffered results, no partial writes.
//  - Buffer: 2-entry FIFO of 256-bit results. hash_valid with <2 entries -> push.
//    hash_valid with 2 entries -> discard, drop_count+1, saturating at all-ones.
//  - Simultaneous push and final-chunk pop with 2 entries: slot freed same cycle, push
//    accepted, no drop.
//  - FSM: IDLE -> EMIT when buffer non-empty (HDR first if macro set). EMIT: chunk_idx 0..5.
//    rd_fifo_wr_en = (state==EMIT||state==HDR) && !rd_fifo_full (combinational on full).
//    chunk_idx advances only on an actual write. After chunk 5 write: pop, chunk_idx=0.
//    Go to EMIT/HDR if another entry remains, else IDLE. No idle bubble between results.
//  - Chunk map, head entry h:
//    idx k<5: h[48k+47:48k]; idx 5: {32'h0, h[255:240]} (upper bits zero-padded).
//  - rd_fifo_wr_data: combinational mux of head entry by chunk_idx; 0 when wr_en=0.
//  - Latency: hash_valid at edge E0 into empty buffer -> FSM leaves IDLE at E1 -> first
//    write at E2. With no full, 6 consecutive writes E2..E7.
//  - rd_fifo_full held high: FSM holds state and chunk_idx, wr_en=0, data head stable.
//  - busy = buffer non-empty || state!=IDLE.
// CONFIGURATION
//  RAH_HASH_SEQ_HDR_EN defined: state HDR precedes EMIT; one extra word per result:
//    {16'hA55A, seq[15:0], drop_count[15:0]}. seq counts emitted results (wraps, reset 0),
//    increments on the last chunk write. 7 words/result, first data chunk at E3.
//  Undefined: no HDR state, no seq counter, 6 words/result.
// STRUCTURE
//  - Package rah_pkg: CHUNK_WIDTH, NUM_CHUNKS, HDR_MAGIC=16'hA55A, FSM state encoding
//    (IDLE, HDR, EMIT).
//  - Sub-module rah_hash_buf: 2-entry 256-bit buffer.
//    Ports: push, push_data, pop, head, count[1:0]. Handles simultaneous push/pop at full.
// TESTING
//  1 hash_valid, data=256'h0123..EF pattern, full=0 -> 6 writes E2..E7.
//    Word5 = {32'h0, data[255:240]}; busy drops after E7.
//  2 full=1 over the 3rd chunk for 4 cycles -> wr_en=0, data held. Resume emits chunks 2..5
//    in order, no duplicates.
//  3 Three hash_valid pulses 1 cycle apart, full=1 throughout -> two buffered, third
//    dropped, drop_count=1. Release full -> 12 words, back-to-back.
//  4 2 entries buffered, new hash_valid in same cycle as chunk-5 write -> accepted,
//    drop_count unchanged, 18 words total.
//  5 rst_n low during chunk 3 -> wr_en=0 immediately, drop_count=0. A new hash after
//    release emits from chunk 0.
//  6 With RAH_HASH_SEQ_HDR_EN: two hashes -> headers {A55A,0000,0000} then
//    {A55A,0001,0000}, 7 words each.

Source files
------------

// File: rtl/rah_pkg.sv
// Shared constants, FSM encoding and chunk-select helper for the RAH hash readback path.
// Optional build macro: RAH_HASH_SEQ_HDR_EN (adds a header word per emitted result).
package rah_pkg;

  localparam int HASH_WIDTH  = 256;
  localparam int CHUNK_WIDTH = 48;
  localparam int NUM_CHUNKS  = 6;
  localparam int DROP_WIDTH  = 16;

  localparam logic [15:0] HDR_MAGIC  = 16'hA55A;
  localparam logic [2:0]  LAST_CHUNK = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_EMIT = 2'd2
  } rah_state_t;

  // Select read-FIFO word idx of a hash; the last word carries the top 16 bits zero-padded.
  function automatic logic [CHUNK_WIDTH-1:0] chunk_sel(input logic [HASH_WIDTH-1:0] h,
                                                       input logic [2:0] idx);
    logic [CHUNK_WIDTH-1:0] w;
    case (idx)
      3'd0:    w = h[47:0];
      3'd1:    w = h[95:48];
      3'd2:    w = h[143:96];
      3'd3:    w = h[191:144];
      3'd4:    w = h[239:192];
      3'd5:    w = {32'h0000_0000, h[255:240]};
      default: w = 48'h0000_0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rah_hash_buf.sv
// Two-entry buffer of 256-bit hash results. A push into a full buffer is taken
// only when a pop happens in the same cycle (the popped slot is reused).
module rah_hash_buf
  import rah_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [HASH_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [HASH_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [HASH_WIDTH-1:0] r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign w_pop_ok  = pop && (r_count != 2'd0);
  assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

  // Storage slots: write the incoming hash at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/rah_hash_readback.sv
// Captures SHA hash1 results into a two-entry buffer and serialises each into
// 48-bit read-FIFO words. The SHA core cannot be stalled: overflow is counted.
// Optional build macro: RAH_HASH_SEQ_HDR_EN -- emits {A55A, seq, drop_count}
// ahead of each result's data words.
module rah_hash_readback
  import rah_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hash_valid,
  input  logic [HASH_WIDTH-1:0]  hash_data,
  input  logic                   rd_fifo_full,
  output logic                   rd_fifo_wr_en,
  output logic [CHUNK_WIDTH-1:0] rd_fifo_wr_data,
  output logic                   busy,
  output logic [DROP_WIDTH-1:0]  drop_count
);

`ifdef RAH_HASH_SEQ_HDR_EN
  localparam rah_state_t FIRST_STATE = ST_HDR;
`else
  localparam rah_state_t FIRST_STATE = ST_EMIT;
`endif

  rah_state_t             r_state;
  rah_state_t             w_state_nxt;
  logic [2:0]             r_chunk_idx;
  logic [2:0]             w_chunk_nxt;
  logic [DROP_WIDTH-1:0]  r_drop_count;
  logic [1:0]             w_buf_count;
  logic [HASH_WIDTH-1:0]  w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_wr_en;
  logic                   w_more;
  logic [CHUNK_WIDTH-1:0] w_hdr_word;

  // A pop with a full buffer frees a slot this cycle, so a coincident hash is kept.
  assign w_push = hash_valid && ((w_buf_count != 2'd2) || w_pop);
  assign w_drop = hash_valid && !w_push;
  // Another result remains after the pop if the other slot is occupied or a hash arrives now.
  assign w_more = (w_buf_count == 2'd2) || hash_valid;

  rah_hash_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (hash_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_buf_count)
  );

`ifdef RAH_HASH_SEQ_HDR_EN
  logic [15:0] r_seq;

  // Emitted-result sequence number, advanced on each result's final data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 16'h0000;
    end else if (w_pop) begin
      r_seq <= r_seq + 16'h0001;
    end else begin
      r_seq <= r_seq;
    end
  end

  assign w_hdr_word = {HDR_MAGIC, r_seq, r_drop_count};
`else
  assign w_hdr_word = 48'h0000_0000_0000;
`endif

  // FSM state and chunk index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_chunk_idx <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_chunk_idx <= w_chunk_nxt;
    end
  end

  // Next state: write whenever emitting and the FIFO has room; hold everything while full.
  always_comb begin
    w_state_nxt = r_state;
    w_chunk_nxt = r_chunk_idx;
    w_pop       = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_buf_count != 2'd0) begin
          w_state_nxt = FIRST_STATE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!rd_fifo_full) begin
          w_wr_en     = 1'b1;
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_EMIT: begin
        if (!rd_fifo_full) begin
          w_wr_en = 1'b1;
          if (r_chunk_idx == LAST_CHUNK) begin
            w_pop       = 1'b1;
            w_chunk_nxt = 3'd0;
            if (w_more) begin
              w_state_nxt = FIRST_STATE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_chunk_nxt = r_chunk_idx + 3'd1;
            w_state_nxt = ST_EMIT;
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_chunk_nxt = 3'd0;
      end
    endcase
  end

  // Saturating count of hashes lost to a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != {DROP_WIDTH{1'b1}})) begin
      r_drop_count <= r_drop_count + {{(DROP_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_drop_count <= r_drop_count;
    end
  end

  // Write-data mux: header, or the selected chunk of the head entry; zero when not writing.
  always_comb begin
    rd_fifo_wr_data = 48'h0000_0000_0000;
    if (!w_wr_en) begin
      rd_fifo_wr_data = 48'h0000_0000_0000;
    end else if (r_state == ST_HDR) begin
      rd_fifo_wr_data = w_hdr_word;
    end else begin
      rd_fifo_wr_data = chunk_sel(w_head, r_chunk_idx);
    end
  end

  assign rd_fifo_wr_en = w_wr_en;
  assign busy          = (w_buf_count != 2'd0) || (r_state != ST_IDLE);
  assign drop_count    = r_drop_count;

endmodule
